layer_output_streamer: RTL and testbench
========================================

Name: layer_output_streamer

Overview:
Consumer for a generator layer's flat result bus. Captures the full N_ELEM x DATA_W flat bus on the layer's one-cycle done pulse, then streams the elements out one per handshake over a valid/ready interface. Sits between a layer's flat output and the next serial stage (next layer's input packer, activation FIFO, or debug/UART dump).
- in_ready gives the upstream controller the permission to pulse start on the layer.

Parameters:
N_ELEM, 256, number of elements in the flat bus
DATA_W, 16, element width (signed Q8.8)
IDX_W, 8, width of element index output (must satisfy 2^IDX_W >= N_ELEM)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_done  input  1  one-cycle capture strobe (layer done)
in_flat  input  DATA_W*N_ELEM  signed flat bus; element i = in_flat[(i+1)*DATA_W-1 -: DATA_W]
in_ready  output  1  high when idle and able to capture
out_valid  output  1  out_data holds a valid element
out_ready  input  1  downstream accepts element
out_data  output  DATA_W  signed element value (after optional activation)
out_index  output  IDX_W  index of element on out_data
out_last  output  1  high with element N_ELEM-1
frame_done  output  1  one-cycle pulse after last element transferred
overrun  output  1  sticky: in_done seen while not idle

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0, overrun=0, capture buffer contents don't-care.
- States: IDLE, STREAM.
- IDLE: in_ready=1. When in_done=1 at a rising edge, do all of the following on that same edge:
  - latch in_flat into the internal buffer;
  - go to STREAM with index 0;
  - set out_valid=1, out_data=element 0, out_index=0, in_ready=0.
- Latency: out_valid rises one cycle after the in_done cycle.
- STREAM:
  - A transfer occurs on any edge where out_valid && out_ready.
  - On a transfer with index < N_ELEM-1: index+1; out_data/out_index update on the same edge; out_valid stays 1 (no bubbles).
  - No transfer (out_ready=0): out_data, out_index and out_last hold stable.
  - out_last=1 exactly while out_index==N_ELEM-1.
  - Transfer of the last element: out_valid=0, out_last=0, out_index=0, go to IDLE, in_ready=1 and frame_done=1 for exactly one cycle.
- in_done while in STREAM: ignored (buffer unchanged, stream continues). overrun is set to 1 and holds until rst.
- Buffer: captured data is independent of in_flat changes after capture.
- in_done on the same edge that transfers the last element: ignored and flagged as overrun, because state is not yet IDLE. in_done in the following cycle is accepted.
- out_ready held high continuously: exactly N_ELEM consecutive transfer cycles.
- Index: counts 0..N_ELEM-1, never wraps mid-frame.
- Reset mid-stream: the frame is abandoned immediately; out_valid drops asynchronously; no frame_done.
- All outputs are registered; none depends combinationally on out_ready.

Optional Feature:
Macro LAYER_STREAM_LRELU_EN.
- Defined: out_data = x when x >= 0, else x >>> 3 (arithmetic shift; leaky slope 0.125, Q8.8 preserved). The activation is applied when the element is loaded into the output register; latency is unchanged.
- Undefined: out_data = x unmodified.

Test Plan:
- Reset: assert rst mid-cycle -> in_ready=1, out_valid=0, overrun=0, frame_done=0 immediately.
- Ramp capture: in_flat element i = i, pulse in_done, out_ready=1 constant -> out_valid rises next cycle; 256 consecutive beats with data=index=0..255; out_last only on 255; frame_done pulse the cycle after; in_ready=1.
- Backpressure: toggle out_ready with a random pattern -> data/index held while out_ready=0; all 256 elements exactly once, in order.
- Overrun: pulse in_done at beat 100 with different in_flat -> stream continues from the original buffer; overrun=1 sticky; new in_done after frame_done accepted normally.
- Last-beat collision: in_done coincident with the last transfer -> ignored, overrun=1; in_done one cycle later -> new frame starts.
- LRELU (macro defined): element 0x0100 -> 0x0100, 0xFF00 (-1.0) -> 0xFFE0 (-0.125), 0xFFFF -> 0xFFFF. Macro undefined: 0xFF00 -> 0xFF00.

Source files
------------

// File: rtl/layer_output_streamer.sv
// layer_output_streamer
// Captures a generator layer's flat result bus on its one-cycle done strobe
// and replays the elements one per valid/ready handshake.
// Optional build macro: LAYER_STREAM_LRELU_EN applies a leaky ReLU
// (negative slope 1/8, Q8.8 preserved) as each element is loaded into the
// output register.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | buffer free, in_ready=1, waiting for in_done to capture
// STREAM | buffer holds a frame, elements presented on out_* in order
module layer_output_streamer #(
    parameter int N_ELEM = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_done,
    input  logic [DATA_W*N_ELEM-1:0] in_flat,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     overrun
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_t            state;
    logic [DATA_W-1:0] buf_mem [N_ELEM];
    logic [IDX_W-1:0]  next_idx;
    logic [DATA_W-1:0] next_elem;
    logic              capture;
    logic              xfer;

    // Output-side activation; identity unless the leaky ReLU build is selected.
    function automatic logic [DATA_W-1:0] activate(input logic [DATA_W-1:0] x);
`ifdef LAYER_STREAM_LRELU_EN
        if (x[DATA_W-1])
            activate = $signed(x) >>> 3;
        else
            activate = x;
`else
        activate = x;
`endif
    endfunction

    assign capture   = (state == IDLE) && in_done;
    assign xfer      = out_valid && out_ready;
    assign next_idx  = out_index + IDX_W'(1);
    assign next_elem = buf_mem[next_idx];

    // Frame buffer: loaded only on an accepted capture, so later in_flat
    // changes and ignored in_done pulses leave the stream untouched.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N_ELEM; i++)
                buf_mem[i] <= in_flat[i*DATA_W +: DATA_W];
        end
    end

    // Streaming FSM with registered handshake outputs and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_done) begin
                        state     <= STREAM;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= activate(in_flat[DATA_W-1:0]);
                        out_index <= '0;
                        out_last  <= (N_ELEM == 1);
                    end
                end
                STREAM: begin
                    // Only one frame fits; a second done while busy is dropped.
                    if (in_done)
                        overrun <= 1'b1;
                    if (xfer) begin
                        if (out_index == LAST_IDX) begin
                            state      <= IDLE;
                            in_ready   <= 1'b1;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            out_index  <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            out_index <= next_idx;
                            out_data  <= activate(next_elem);
                            out_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_streamer.sv
// Bench for layer_output_streamer: random frames checked against an
// array/arithmetic reference of the element stream.
module tb_layer_output_streamer;

    localparam int N = 256;
    localparam int W = 16;
    localparam int IW = 8;
    localparam int BUDGET = 4000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_done;
    logic [W*N-1:0] in_flat;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_index;
    logic           out_last;
    logic           frame_done;
    logic           overrun;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [W-1:0] frame [N];

    layer_output_streamer #(.N_ELEM(N), .DATA_W(W), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .in_done(in_done), .in_flat(in_flat),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference activation: floor division by 8 of negative Q8.8 values.
    function automatic logic [W-1:0] act_model(input logic [W-1:0] x);
        int v;
        v = x[W-1] ? int'(x) - 65536 : int'(x);
`ifdef LAYER_STREAM_LRELU_EN
        if (v < 0) begin
            if (v % 8 != 0) v = v / 8 - 1;
            else            v = v / 8;
        end
`endif
        return v[W-1:0];
    endfunction

    task automatic randomize_frame();
        for (int i = 0; i < N; i++) frame[i] = W'($urandom);
    endtask

    task automatic scramble_flat();
        for (int i = 0; i < N; i++) in_flat[i*W +: W] = W'($urandom);
    endtask

    // Called at a negedge while idle; returns at the first negedge after capture.
    task automatic start_frame();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        for (int i = 0; i < N; i++) in_flat[i*W +: W] = frame[i];
        in_done = 1'b1;
        @(negedge clk);
        in_done = 1'b0;
        scramble_flat();
        chk("frame_done_low", frame_done, 0);
        chk("busy_in_ready", in_ready, 0);
    endtask

    // mode 0: ready always high; mode 1: random ready.
    // ovr_beat: beat on which an extra in_done is pulsed (ready forced high).
    task automatic stream_frame(input int mode, input int ovr_beat, output int cycles);
        int  k;
        logic rdy;
        k = 0;
        cycles = 0;
        while (k < N && cycles < BUDGET) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_data", out_data, act_model(frame[k]));
            chk("beat_index", out_index, k);
            chk("beat_last", out_last, (k == N - 1));
            in_done = 1'b0;
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == ovr_beat) begin
                rdy = 1'b1;
                in_done = 1'b1;
                scramble_flat();
            end
            out_ready = rdy;
            if (rdy) k++;
            @(negedge clk);
            cycles++;
        end
        in_done = 1'b0;
        out_ready = 1'b0;
        chk("stream_in_budget", (cycles < BUDGET), 1);
        chk("end_valid", out_valid, 0);
        chk("end_frame_done", frame_done, 1);
        chk("end_in_ready", in_ready, 1);
        chk("end_last", out_last, 0);
        chk("end_index", out_index, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_done = 1'b0;
        out_ready = 1'b0;
        in_flat = '0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp frame, continuous ready: exactly N back-to-back beats.
        for (int i = 0; i < N; i++) frame[i] = W'(i);
        start_frame();
        stream_frame(0, -1, cyc);
        chk("ramp_cycles", cyc, N);
        chk("ramp_overrun", overrun, 0);

        // Random data under random backpressure.
        randomize_frame();
        start_frame();
        stream_frame(1, -1, cyc);
        chk("bp_overrun", overrun, 0);

        // Extra in_done mid-stream is ignored and flagged.
        randomize_frame();
        start_frame();
        stream_frame(1, 100, cyc);
        chk("ovr_set", overrun, 1);

        // Next frame accepted normally; overrun stays sticky.
        randomize_frame();
        start_frame();
        stream_frame(0, -1, cyc);
        chk("ovr_sticky", overrun, 1);

        // in_done on the last-transfer edge is dropped; one cycle later it is taken.
        randomize_frame();
        start_frame();
        stream_frame(1, N - 1, cyc);
        chk("collide_overrun", overrun, 1);
        randomize_frame();
        start_frame();
        stream_frame(1, -1, cyc);

        // Asynchronous reset in the middle of a frame.
        randomize_frame();
        start_frame();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_out_index", out_index, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_valid", out_valid, 0);
            chk("postrst_frame_done", frame_done, 0);
        end
        out_ready = 1'b0;

        // Activation corner values at the head of a random frame.
        randomize_frame();
        frame[0] = 16'h0100;
        frame[1] = 16'hFF00;
        frame[2] = 16'hFFFF;
        frame[3] = 16'h8000;
        frame[4] = 16'h7FFF;
        frame[5] = 16'hFFF9;
        start_frame();
        stream_frame(1, -1, cyc);
        chk("act_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
